// File: rtl/dmem_bridge.sv
// CPU data-memory port to single-outstanding bus bridge: posted writes through a
// small FIFO, blocking reads that drain the FIFO first to keep program order.
`timescale 1ns/1ps
module dmem_bridge #(
    parameter int WBUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        cpu_en,
    input  logic [3:0]  cpu_mem_write_en,
    input  logic        cpu_mem_read_en,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_write_data,
    output logic [31:0] cpu_mem_read_data,
    output logic        bus_req,
    output logic [3:0]  bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wentry_t;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

    wentry_t       wbuf_q [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic          rd_pend_q, rd_pend_d;
    logic [29:0]   rd_waddr_q;
    logic [31:0]   rdata_q;
    logic          bus_req_q, bus_req_d;
    logic [3:0]    bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic          rd_done;

    logic    wbuf_full, wbuf_empty, cpu_wr, push, pop, rd_acc;
    wentry_t head;
    logic    addr_lsb_unused;

    // Byte offset never reaches the bus; lanes are selected by the strobes.
    assign addr_lsb_unused = ^cpu_mem_addr[1:0];

    assign wbuf_full  = (cnt_q == CW'(WBUF_DEPTH));
    assign wbuf_empty = (cnt_q == '0);
    assign cpu_wr     = |cpu_mem_write_en;
    assign head       = wbuf_q[rd_ptr_q];

    // The stall is built from registered state only, so bus_ack never ripples into the CPU.
    assign cpu_en = ~rst & en & ~rd_pend_q & ~(wbuf_full & cpu_wr);
    assign push   = cpu_en & cpu_wr;
    assign rd_acc = cpu_en & ~cpu_wr & cpu_mem_read_en;
    assign pop    = (state_q == S_WR) & bus_ack;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rd_done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!wbuf_empty) begin
                    state_d     = S_WR;
                    bus_req_d   = 1'b1;
                    bus_we_d    = head.strb;
                    bus_addr_d  = {head.waddr, 2'b00};
                    bus_wdata_d = head.data;
                end else if (rd_pend_q || rd_acc) begin
                    // A read accepted this cycle goes straight out to meet the one-cycle-ack latency.
                    state_d    = S_RD;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 4'b0000;
                    bus_addr_d = rd_pend_q ? {rd_waddr_q, 2'b00} : {cpu_mem_addr[31:2], 2'b00};
                end
            end
            S_WR: begin
                if (bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                end
            end
            S_RD: begin
                if (bus_ack) begin
                    state_d   = S_IDLE;
                    bus_req_d = 1'b0;
                    rd_done   = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_pend_d = rd_pend_q;
        if (rd_done)
            rd_pend_d = 1'b0;
        else if (rd_acc)
            rd_pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rd_pend_q   <= 1'b0;
            rd_waddr_q  <= '0;
            rdata_q     <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_pend_q   <= rd_pend_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (rd_acc)
                rd_waddr_q <= cpu_mem_addr[31:2];
            if (rd_done)
                rdata_q <= bus_rdata;
        end
    end

    // Entry storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push)
            wbuf_q[wr_ptr_q] <= '{waddr: cpu_mem_addr[31:2], data: cpu_mem_write_data,
                                  strb: cpu_mem_write_en};
    end

    assign bus_req           = bus_req_q;
    assign bus_we            = bus_we_q;
    assign bus_addr          = bus_addr_q;
    assign bus_wdata         = bus_wdata_q;
    assign cpu_mem_read_data = rdata_q;
endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: directed CPU traffic, a responding bus memory,
// and monitors that pop expected bus transactions and read returns.
`timescale 1ns/1ps
module tb_dmem_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        cpu_en;
    logic [3:0]  cpu_mem_write_en = '0;
    logic        cpu_mem_read_en = 1'b0;
    logic [31:0] cpu_mem_addr = '0;
    logic [31:0] cpu_mem_write_data = '0;
    logic [31:0] cpu_mem_read_data;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    dmem_bridge #(.WBUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .cpu_en(cpu_en),
        .cpu_mem_write_en(cpu_mem_write_en), .cpu_mem_read_en(cpu_mem_read_en),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_write_data(cpu_mem_write_data),
        .cpu_mem_read_data(cpu_mem_read_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic [31:0] data;
        int          stall;
    } rd_exp_t;

    bus_exp_t bus_q[$];
    rd_exp_t  rd_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mem [logic [31:0]];
    int ack_delay = 0;
    bit resp_en = 1'b1;
    bit stray_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic exp_bus(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit chk_wd, input int len);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.chk_wd = chk_wd; e.len = len;
        bus_q.push_back(e);
    endtask

    task automatic exp_rd(input logic [31:0] data, input int stall);
        rd_exp_t e;
        e.data = data; e.stall = stall;
        rd_q.push_back(e);
    endtask

    // Bus slave: acks after ack_delay extra req cycles, backed by a word memory.
    int          resp_cnt = 0;
    logic [31:0] resp_w;
    always @(negedge clk) begin
        if (stray_ack) begin
            bus_ack   = 1'b1;
            bus_rdata = 32'hFFFF_FFFF;
        end else if (resp_en && bus_req) begin
            if (resp_cnt == ack_delay) begin
                bus_ack = 1'b1;
                resp_w  = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
                if (bus_we == 4'b0000) begin
                    bus_rdata = resp_w;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (bus_we[b]) resp_w[b*8 +: 8] = bus_wdata[b*8 +: 8];
                    mem[bus_addr] = resp_w;
                end
            end else begin
                bus_ack = 1'b0;
            end
            resp_cnt++;
        end else begin
            bus_ack  = 1'b0;
            resp_cnt = 0;
        end
    end

    // Bus monitor: one expected entry per rising bus_req.
    bit          bm_prev = 1'b0;
    bit          bm_have = 1'b0;
    bit          bm_stable = 1'b1;
    int          bm_len = 0;
    bus_exp_t    bm_cur;
    logic [3:0]  bm_we;
    logic [31:0] bm_addr, bm_wdata;
    always @(negedge clk) begin
        if (bus_req && !bm_prev) begin
            if (bus_q.size() == 0) begin
                total_cnt++;
                bm_have = 1'b0;
                $display("FAIL bus_unexpected: got addr 0x%08h we %b, required no transaction",
                         bus_addr, bus_we);
            end else begin
                bm_cur  = bus_q.pop_front();
                bm_have = 1'b1;
                chk("bus_we", 32'(bus_we), 32'(bm_cur.we));
                chk("bus_addr", bus_addr, bm_cur.addr);
                if (bm_cur.chk_wd) chk("bus_wdata", bus_wdata, bm_cur.wdata);
            end
            bm_we = bus_we; bm_addr = bus_addr; bm_wdata = bus_wdata;
            bm_len = 1;
            bm_stable = 1'b1;
        end else if (bus_req) begin
            bm_len++;
            if (bus_we !== bm_we || bus_addr !== bm_addr || bus_wdata !== bm_wdata)
                bm_stable = 1'b0;
        end else if (bm_prev && bm_have) begin
            if (bm_cur.len > 0) chk("bus_req_len", 32'(bm_len), 32'(bm_cur.len));
            chk("bus_stable", 32'(bm_stable), 32'd1);
        end
        bm_prev = bus_req;
    end

    // Read monitor: data is due in the first cpu_en=1 cycle after an accepted read.
    bit rm_wait = 1'b0;
    int rm_stall = 0;
    rd_exp_t rm_e;
    always @(negedge clk) begin
        if (rst) begin
            rm_wait = 1'b0;
        end else begin
            if (rm_wait) begin
                if (cpu_en) begin
                    rm_wait = 1'b0;
                    if (rd_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL rd_unexpected: got 0x%08h, required no read", cpu_mem_read_data);
                    end else begin
                        rm_e = rd_q.pop_front();
                        chk("rd_data", cpu_mem_read_data, rm_e.data);
                        if (rm_e.stall >= 0) chk("rd_stall", 32'(rm_stall), 32'(rm_e.stall));
                    end
                end else begin
                    rm_stall++;
                end
            end
            if (cpu_en && cpu_mem_read_en && cpu_mem_write_en == 4'b0000) begin
                rm_wait  = 1'b1;
                rm_stall = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Holds a request until cpu_en accepts it; returns the number of stalled cycles.
    task automatic issue(input logic [3:0] we, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        cpu_mem_write_en = we; cpu_mem_read_en = rd;
        cpu_mem_addr = addr; cpu_mem_write_data = data;
        while (!ok && waits < 50) begin
            @(negedge clk);
            if (cpu_en) ok = 1'b1;
            else waits++;
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL issue_timeout: got no accept for addr 0x%08h, required accept", addr);
        end
        @(posedge clk); #1;
        cpu_mem_write_en = '0; cpu_mem_read_en = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while ((bus_q.size() != 0 || rd_q.size() != 0 || bus_req) && i < 300) begin
            cyc(1);
            i++;
        end
        if (i == 300) begin
            total_cnt++;
            $display("FAIL idle_timeout: got bus_q %0d rd_q %0d, required 0 0", bus_q.size(), rd_q.size());
        end
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int w, w2, w3;
        bit ok;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", cpu_mem_read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(1);

        // Single word write, ack in the 4th req cycle.
        ack_delay = 3;
        exp_bus(4'hF, 32'h100, 32'hDEADBEEF, 1'b1, 4);
        issue(4'hF, 1'b0, 32'h100, 32'hDEADBEEF, w);
        chk("t1_waits", 32'(w), 32'd0);
        ok = 1'b1;
        repeat (8) begin @(negedge clk); if (!cpu_en) ok = 1'b0; end
        chk("t1_cpu_en_high", 32'(ok), 32'd1);
        @(posedge clk); #1;
        wait_idle();

        // Three byte stores into a 2-deep buffer with a slow bus.
        ack_delay = 5;
        exp_bus(4'b0001, 32'h300, 32'hAAAAAAAA, 1'b1, 6);
        exp_bus(4'b0010, 32'h300, 32'hBBBBBBBB, 1'b1, 6);
        exp_bus(4'b0100, 32'h300, 32'hCCCCCCCC, 1'b1, 6);
        issue(4'b0001, 1'b0, 32'h300, 32'hAAAAAAAA, w);
        issue(4'b0010, 1'b0, 32'h301, 32'hBBBBBBBB, w2);
        issue(4'b0100, 1'b0, 32'h302, 32'hCCCCCCCC, w3);
        chk("t2_waits1", 32'(w), 32'd0);
        chk("t2_waits2", 32'(w2), 32'd0);
        chk("t2_waits3", 32'(w3), 32'd6);
        wait_idle();

        // Store then load of the same word; a byte-merged readback of the previous stores.
        ack_delay = 1;
        exp_bus(4'hF, 32'h200, 32'h12345678, 1'b1, 2);
        exp_bus(4'h0, 32'h200, 32'h0, 1'b0, 2);
        exp_rd(32'h12345678, -1);
        issue(4'hF, 1'b0, 32'h200, 32'h12345678, w);
        issue(4'h0, 1'b1, 32'h200, 32'h0, w2);
        chk("t3_sw_waits", 32'(w), 32'd0);
        chk("t3_lw_waits", 32'(w2), 32'd0);
        wait_idle();
        exp_bus(4'h0, 32'h300, 32'h0, 1'b0, 2);
        exp_rd(32'h00CCBBAA, -1);
        issue(4'h0, 1'b1, 32'h303, 32'h0, w);
        wait_idle();

        // Minimum-latency read.
        ack_delay = 0;
        mem[32'h400] = 32'hCAFEF00D;
        exp_bus(4'h0, 32'h400, 32'h0, 1'b0, 1);
        exp_rd(32'hCAFEF00D, 1);
        issue(4'h0, 1'b1, 32'h400, 32'h0, w);
        @(negedge clk);
        chk("t4_req_T1", 32'(bus_req), 32'd1);
        chk("t4_cpu_en_T1", 32'(cpu_en), 32'd0);
        @(negedge clk);
        chk("t4_cpu_en_T2", 32'(cpu_en), 32'd1);
        chk("t4_data_T2", cpu_mem_read_data, 32'hCAFEF00D);
        @(posedge clk); #1;
        wait_idle();

        // Reset while a read waits for its ack, then a stray ack in IDLE.
        resp_en = 1'b0;
        mem[32'h500] = 32'h55AA55AA;
        exp_bus(4'h0, 32'h500, 32'h0, 1'b0, 0);
        issue(4'h0, 1'b1, 32'h500, 32'h0, w);
        cyc(3);
        chk("t5_req_before_rst", 32'(bus_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_req_async", 32'(bus_req), 32'd0);
        chk("t5_rdata_rst", cpu_mem_read_data, 32'd0);
        chk("t5_cpu_en_rst", 32'(cpu_en), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        stray_ack = 1'b1;
        cyc(1);
        stray_ack = 1'b0;
        ok = 1'b1;
        repeat (4) begin @(negedge clk); if (bus_req || cpu_mem_read_data != 32'd0) ok = 1'b0; end
        chk("t5_stray_ack_ignored", 32'(ok), 32'd1);
        @(posedge clk); #1;
        resp_en = 1'b1;
        ack_delay = 2;
        exp_bus(4'h0, 32'h500, 32'h0, 1'b0, 3);
        exp_rd(32'h55AA55AA, 3);
        issue(4'h0, 1'b1, 32'h500, 32'h0, w);
        wait_idle();

        // en dropped while a write is in flight.
        ack_delay = 3;
        exp_bus(4'hF, 32'h600, 32'h0BADF00D, 1'b1, 4);
        issue(4'hF, 1'b0, 32'h600, 32'h0BADF00D, w);
        en = 1'b0;
        ok = 1'b1;
        repeat (10) begin @(negedge clk); if (cpu_en) ok = 1'b0; end
        chk("t6_cpu_en_low", 32'(ok), 32'd0 + 32'd1);
        chk("t6_bus_idle", 32'(bus_req), 32'd0);
        @(posedge clk); #1;
        en = 1'b1;
        @(negedge clk);
        chk("t6_cpu_en_back", 32'(cpu_en), 32'd1);
        @(posedge clk); #1;
        exp_bus(4'h0, 32'h600, 32'h0, 1'b0, 4);
        exp_rd(32'h0BADF00D, -1);
        issue(4'h0, 1'b1, 32'h600, 32'h0, w);
        wait_idle();

        chk("end_bus_q", 32'(bus_q.size()), 32'd0);
        chk("end_rd_q", 32'(rd_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameters: WBUF_DEPTH, default 2, write-buffer entries; SHALL be a power of two and at least 2.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  global run enable from the system.
REQ-006 cpu_en  out  1  CPU pipeline enable; drives the CPU en input.
REQ-007 cpu_mem_write_en  in  4  byte-lane write strobes; bit 3 = bits 31:24.
REQ-008 cpu_mem_read_en  in  1  word read request.
REQ-009 cpu_mem_addr  in  32  byte address.
REQ-010 cpu_mem_write_data  in  32  lane-replicated store data.
REQ-011 cpu_mem_read_data  out  32  read data returned to the CPU M stage.
REQ-012 bus_req  out  1  bus transaction request.
REQ-013 bus_we  out  4  lane strobes; 4'b0000 = read.
REQ-014 bus_addr  out  32  bus address, word-aligned (bits 1:0 forced 0).
REQ-015 bus_wdata  out  32  bus write data.
REQ-016 bus_ack  in  1  single-cycle completion pulse.
REQ-017 bus_rdata  in  32  read data, valid in the bus_ack cycle.

Function
REQ-018 A CPU request SHALL be accepted only in a cycle with cpu_en=1; request inputs in cpu_en=0 cycles SHALL be ignored.
REQ-019 Accepted write (cpu_mem_write_en!=0) SHALL push {addr, data, strobes} into a FIFO write buffer; if cpu_mem_read_en is also high, the write SHALL win and the read SHALL be dropped.
REQ-020 Accepted read SHALL set rd_pending and capture the address; the read SHALL NOT reach the bus until the write buffer is empty (program order).
REQ-021 cpu_en = en & ~rd_pending & ~(wbuf_full & (cpu_mem_write_en!=0)); the full-stall SHALL NOT consider a same-cycle pop.
REQ-022 cpu_en SHALL depend only on en, registered state and cpu_mem_write_en; there SHALL be no path from bus_ack or bus_rdata to cpu_en.
REQ-023 Bus FSM states: IDLE, WR, RD.
REQ-024 IDLE->WR when the buffer is non-empty; IDLE->RD when the buffer is empty and rd_pending=1.
REQ-025 WR->IDLE on bus_ack, popping the head; RD->IDLE on bus_ack, latching bus_rdata and clearing rd_pending.
REQ-026 bus_req SHALL be registered and high exactly in WR/RD; bus_we/bus_addr/bus_wdata SHALL be stable while bus_req=1.
REQ-027 bus_req SHALL be low for at least one cycle between transactions; bus_ack while in IDLE SHALL be ignored.
REQ-028 bus_ack SHALL advance the FSM even when en=0; en SHALL gate only cpu_en.
REQ-029 cpu_mem_read_data SHALL hold the last latched read word until the next read completes; it is consumed in the first cpu_en=1 cycle after the read is accepted.
REQ-030 Minimum read latency with an empty buffer and ack in the first req cycle: accept at cycle T, bus_req at T+1, ack at T+1, cpu_en=1 and data valid at T+2.
REQ-031 Pointers SHALL wrap modulo WBUF_DEPTH; an occupancy counter of width log2(WBUF_DEPTH)+1 SHALL define full/empty; push and pop in the same cycle SHALL leave occupancy unchanged.

Reset
REQ-032 On rst, asynchronously: FSM=IDLE, buffer empty, rd_pending=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, cpu_mem_read_data=0, cpu_en=0 while rst is high.
REQ-033 Reset mid-transaction SHALL abandon the transaction and discard buffered writes; after release, bus_req SHALL stay low until a new request is accepted.

Verification
REQ-034 Single write: SW 0xDEADBEEF to 0x100, strobes 1111, ack after 3 cycles -> bus_req high for exactly 4 cycles with addr 0x100 and we 1111; cpu_en stays 1 throughout.
REQ-035 Buffer full: 3 back-to-back SB writes (WBUF_DEPTH=2), bus ack delayed 5 cycles -> cpu_en=0 on the third write until the first ack, then the third write is accepted; bus order matches issue order.
REQ-036 RAW ordering: SW 0x12345678 to 0x200, then LW 0x200 -> the read bus_req starts only after the write ack; cpu_mem_read_data=0x12345678 in the first cpu_en=1 cycle.
REQ-037 Min-latency read: empty buffer, ack in the first req cycle, bus_rdata=0xCAFEF00D -> cpu_en low for exactly 1 cycle; data valid at T+2.
REQ-038 Reset during RD wait -> bus_req drops asynchronously, cpu_mem_read_data=0; a later bus_ack has no effect; the next LW completes normally.
REQ-039 en=0 while a write is in flight -> ack still pops the entry; cpu_en stays 0 until en=1.
